mem_bus_master: RTL and testbench

//  CPU-side initiator for the asynchronous memory bus: Abus, bidirectional Dbus, rdM/wrM strobes and the mfc completion flag.
//  - Takes single-word read/write requests from the control unit (MAR/MDR side).
//  - Sequences the strobes and waits for a full mfc low->high cycle.
//  - Returns read data or a timeout error with a one-cycle done pulse.
//  - Sits between the datapath and memoryModule-class responders.

---
 rtl/mem_bus_master_pkg.sv | 18 +
 rtl/mem_bus_master_sync_2ff.sv | 26 ++
 rtl/mem_bus_master.sv | 164 ++++++++++++++++
 tb/tb_mem_bus_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the asynchronous memory bus initiator.
//  - default bus widths and timeout
//  - FSM state encoding (3-bit)
package mem_bus_master_pkg;

    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_bus_master_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (mfc).
// Ports:
//  clk  in  system clock
//  rst  in  synchronous active-high reset (clears both flops)
//  d    in  asynchronous input
//  q    out synchronized output, two clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the asynchronous memory bus (Abus, Dbus, rdM/wrM,
// mfc). Accepts one read/write at a time, sequences the strobes, waits for a
// full mfc low->high cycle and reports completion with a one-cycle done pulse
// (err=1 on timeout).
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  req/we/addr/wdata request from the control unit, sampled in IDLE only
//  busy              high from the cycle after acceptance through the done cycle
//  done, err         completion pulse and its timeout flag
//  rdata             last successfully read word
//  Abus, Dbus        memory address bus, bidirectional data bus
//  rdM, wrM          memory strobes
//  mfc               memory function complete (asynchronous)
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] Abus,
    inout  wire  [DW-1:0] Dbus,
    output logic          rdM,
    output logic          wrM,
    input  logic          mfc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] abus_d;
    logic [DW-1:0] rdata_d;
    logic          rdm_d, wrm_d, dbus_oe, oe_d;
    logic          busy_d, done_d, err_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          mfc_s;

    sync_2ff u_mfc_sync (
        .clk (clk),
        .rst (rst),
        .d   (mfc),
        .q   (mfc_s)
    );

    // Write data stays on the bus through HOLD so it outlives wrM by a cycle.
    assign Dbus = dbus_oe ? wdata_q : {DW{1'bz}};

    // cnt_q counts completed strobe-high cycles; saturates at TIMEOUT.
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        abus_d  = Abus;
        rdata_d = rdata;
        rdm_d   = rdM;
        wrm_d   = wrM;
        oe_d    = dbus_oe;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    wdata_d = wdata;
                    abus_d  = addr;
                    oe_d    = we;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                rdm_d   = ~we_q;
                wrm_d   = we_q;
                cnt_d   = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // A stale mfc=1 from the previous access must drop first.
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(TIMEOUT)) begin
                    rdm_d   = 1'b0;
                    wrm_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (!mfc_s) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mfc_s) begin
                    if (!we_q)
                        rdata_d = Dbus;
                    rdm_d   = 1'b0;
                    wrm_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    rdm_d   = 1'b0;
                    wrm_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HOLD: begin
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            wdata_q <= '0;
            Abus    <= '0;
            rdata   <= '0;
            rdM     <= 1'b0;
            wrM     <= 1'b0;
            dbus_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            Abus    <= abus_d;
            rdata   <= rdata_d;
            rdM     <= rdm_d;
            wrM     <= wrm_d;
            dbus_oe <= oe_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: mem_bus_master paired with a behavioural memory responder.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, mfc = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy, done, err, rdM, wrM;
    logic [DW-1:0] rdata;
    logic [AW-1:0] Abus;
    wire  [DW-1:0] Dbus;

    logic [DW-1:0] mem [0:1023];
    logic          mem_oe = 1'b0;
    logic [DW-1:0] mem_drv = '0;
    logic          stuck = 1'b0;
    assign Dbus = mem_oe ? mem_drv : {DW{1'bz}};

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, drv_rd_cnt = 0;

    mem_bus_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .Abus(Abus),
        .Dbus(Dbus), .rdM(rdM), .wrM(wrM), .mfc(mfc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        if (rdM) rd_cnt <= rd_cnt + 1;
        if (wrM) wr_cnt <= wr_cnt + 1;
        if (rdM && wrM) both_cnt <= both_cnt + 1;
        if (rdM && dut.dbus_oe) drv_rd_cnt <= drv_rd_cnt + 1;
    end

    // Memory responder: mfc low 2ns after a strobe rises, high 30ns later
    // (3 clk cycles low); read data driven until the strobe drops.
    initial begin
        forever begin
            @(posedge rdM or posedge wrM);
            if (!stuck) begin
                #2 mfc = 1'b0;
                if (wrM) mem[Abus[9:0]] = Dbus;
                else begin
                    mem_drv = mem[Abus[9:0]];
                    mem_oe  = 1'b1;
                end
                #30 mfc = 1'b1;
            end
            wait (!rdM && !wrM);
            #2 mem_oe = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request for one edge; returns at the negedge after acceptance.
    task automatic start(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int c);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, done, 1'b1);
        c = cyc;
    endtask

    task automatic to_idle(input string tag);
        @(negedge clk);
        chk({tag, " busy off"}, busy, 1'b0);
        chk({tag, " done off"}, done, 1'b0);
    endtask

    initial begin
        int c0, c1, d0, r0, w0, n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = 16'h818F;
        mem[4] = 16'h85EE;
        mem[5] = 16'h0001;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst rdata", rdata, 16'h0);
        chk("rst Abus", Abus, 16'h0);
        chk("rst rdM", rdM, 1'b0);
        chk("rst wrM", wrM, 1'b0);
        chk("rst oe", dut.dbus_oe, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1. read addr 0; accept edge -> done edge is 7 cycles with this
        // responder (SETUP, 2 stale mfc_s cycles, 3 low, 1 sync to high)
        w0 = wr_cnt; r0 = rd_cnt;
        start(1'b0, 16'd0, 16'h0);
        c0 = cyc;
        chk("rd busy", busy, 1'b1);
        wait_done("rd", c1);
        chk("rd latency", c1 - c0, 7);
        chk("rd err", err, 1'b0);
        chk("rd rdata", rdata, 16'h818F);
        chk("rd busy in done", busy, 1'b1);
        to_idle("rd");
        chk("rd rdM pulse len", rd_cnt - r0, 6);
        chk("rd no wrM", wr_cnt - w0, 0);

        // 2. write 600 = 1234, then read it back
        start(1'b1, 16'd600, 16'h1234);
        chk("wr setup wrM low", wrM, 1'b0);
        chk("wr setup Dbus", Dbus, 16'h1234);
        chk("wr setup Abus", Abus, 16'd600);
        wait_done("wr", c1);
        chk("wr err", err, 1'b0);
        chk("wr hold wrM", wrM, 1'b0);
        chk("wr hold oe", dut.dbus_oe, 1'b1);
        chk("wr hold Dbus", Dbus, 16'h1234);
        to_idle("wr");
        chk("wr released", dut.dbus_oe, 1'b0);
        chk("wr mem", mem[600], 16'h1234);
        start(1'b0, 16'd600, 16'h0);
        wait_done("rd600", c1);
        chk("rd600 rdata", rdata, 16'h1234);
        to_idle("rd600");

        // 3. timeout: mfc never drops; done 8 cycles after strobe rises
        stuck = 1'b1;
        start(1'b0, 16'd0, 16'h0);
        @(negedge clk);
        chk("to rdM", rdM, 1'b1);
        c0 = cyc;
        wait_done("to", c1);
        chk("to latency", c1 - c0, 8);
        chk("to err", err, 1'b1);
        chk("to rdata kept", rdata, 16'h1234);
        chk("to rdM low", rdM, 1'b0);
        chk("to wrM low", wrM, 1'b0);
        to_idle("to");
        chk("to err pulse", err, 1'b0);
        stuck = 1'b0;
        repeat (2) @(negedge clk);

        // 4. request during busy is dropped
        d0 = done_cnt;
        start(1'b0, 16'd0, 16'h0);
        @(negedge clk);
        req = 1'b1; addr = 16'd4;
        @(negedge clk);
        req = 1'b0;
        chk("rej Abus mid", Abus, 16'd0);
        wait_done("rej", c1);
        chk("rej Abus", Abus, 16'd0);
        chk("rej rdata", rdata, 16'h818F);
        repeat (4) @(negedge clk);
        chk("rej one done", done_cnt - d0, 1);
        chk("rej idle", busy, 1'b0);

        // back-to-back reads 4, 5
        start(1'b0, 16'd4, 16'h0);
        wait_done("b2b4", c1);
        chk("b2b4 rdata", rdata, 16'h85EE);
        @(negedge clk);
        chk("b2b idle gap", busy, 1'b0);
        start(1'b0, 16'd5, 16'h0);
        chk("b2b5 accepted", busy, 1'b1);
        wait_done("b2b5", c1);
        chk("b2b5 rdata", rdata, 16'h0001);
        to_idle("b2b5");

        // 5. reset while waiting for mfc high
        start(1'b0, 16'd0, 16'h0);
        n = 0;
        while (dut.state_q != S_WAIT_HI && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid reached WAIT_HI", dut.state_q, S_WAIT_HI);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("mid rdM", rdM, 1'b0);
        chk("mid oe", dut.dbus_oe, 1'b0);
        chk("mid busy", busy, 1'b0);
        chk("mid done", done, 1'b0);
        chk("mid rdata", rdata, 16'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid no done", done_cnt - d0, 0);
        start(1'b0, 16'd0, 16'h0);
        wait_done("post", c1);
        chk("post rdata", rdata, 16'h818F);
        chk("post err", err, 1'b0);
        to_idle("post");

        chk("never rdM&wrM", both_cnt, 0);
        chk("never drive on read", drv_rd_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
